// File: rtl/two_level_predictor_if.sv
// Fetch-side bundle of the two-level direction predictor: lookup request,
// registered per-slot hints and graduate-stage training ports.
interface two_level_predictor_if #(
    parameter int VADDR_W      = 32,
    parameter int NUM_FETCH    = 4,
    parameter int NUM_FEEDBACK = 2
);
    logic                            fetch_valid;
    logic [VADDR_W-1:0]              fetch_addr;
    logic                            stall;
    logic                            flush;
    logic                            pred_valid;
    logic [NUM_FETCH-1:0]            pred_taken;
    logic [NUM_FEEDBACK-1:0]         fb_valid;
    logic [NUM_FEEDBACK*VADDR_W-1:0] fb_addr;
    logic [NUM_FEEDBACK-1:0]         fb_taken;

    modport master (
        output fetch_valid, fetch_addr, stall, flush, fb_valid, fb_addr, fb_taken,
        input  pred_valid, pred_taken
    );

    modport slave (
        input  fetch_valid, fetch_addr, stall, flush, fb_valid, fb_addr, fb_taken,
        output pred_valid, pred_taken
    );
endinterface

// File: rtl/two_level_predictor.sv
// Two-level branch direction predictor: history (per-address BHT or global GHR)
// concatenated with the address index selects a saturating counter in the PHT.
module two_level_predictor #(
    parameter int VADDR_W      = 32,
    parameter int NUM_FETCH    = 4,
    parameter int NUM_FEEDBACK = 2,
    parameter int BHT_ENTRIES  = 1024,
    parameter int HIST_DEPTH   = 4,
    parameter int CTR_W        = 2,
    parameter int GLOBAL_HIST  = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    two_level_predictor_if.slave  bus
);
    localparam int IDX_W     = $clog2(BHT_ENTRIES);
    localparam int PIDX_W    = IDX_W + HIST_DEPTH;
    localparam int PHT_DEPTH = 2 ** PIDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};

    function automatic logic [CTR_W-1:0] ctr_sat(input logic [CTR_W-1:0] c, input logic taken);
        if (taken) return (c == CTR_MAX) ? c : c + 1'b1;
        return (c == '0) ? c : c - 1'b1;
    endfunction

    logic [HIST_DEPTH-1:0] bht_q [BHT_ENTRIES];
    logic [CTR_W-1:0]      pht_q [PHT_DEPTH];
    logic [HIST_DEPTH-1:0] ghr_q, ghr_d;

    logic                  pending_q, pending_d;
    logic [VADDR_W-1:0]    pending_addr_q, pending_addr_d;
    logic                  pred_valid_q, pred_valid_d;
    logic [NUM_FETCH-1:0]  pred_taken_q, pred_taken_d;

    logic [VADDR_W-1:0]    lk_addr;
    logic [NUM_FETCH-1:0]  lk_taken;

    logic [IDX_W-1:0]      fb_idx      [NUM_FEEDBACK];
    logic [PIDX_W-1:0]     fb_pidx     [NUM_FEEDBACK];
    logic [HIST_DEPTH-1:0] fb_hist_new [NUM_FEEDBACK];
    logic [CTR_W-1:0]      fb_ctr_new  [NUM_FEEDBACK];

    // Lookup always reads the pre-update tables; a pending replay takes the address slot.
    always_comb begin : lookup
        logic [VADDR_W-1:0]    slot_addr;
        logic [IDX_W-1:0]      slot_idx;
        logic [HIST_DEPTH-1:0] slot_hist;
        lk_addr  = pending_q ? pending_addr_q : bus.fetch_addr;
        lk_taken = '0;
        for (int i = 0; i < NUM_FETCH; i++) begin
            slot_addr   = lk_addr + VADDR_W'(4 * i);
            slot_idx    = IDX_W'(slot_addr >> 2);
            slot_hist   = (GLOBAL_HIST != 0) ? ghr_q : bht_q[slot_idx];
            lk_taken[i] = pht_q[{slot_idx, slot_hist}][CTR_W-1];
        end
    end

    // Ports train in order; later ports forward history/counter results of earlier ports.
    always_comb begin : train
        logic [HIST_DEPTH-1:0] hist;
        logic [CTR_W-1:0]      ctr;
        logic [VADDR_W-1:0]    word;
        ghr_d = ghr_q;
        for (int j = 0; j < NUM_FEEDBACK; j++) begin
            word      = bus.fb_addr[j*VADDR_W +: VADDR_W];
            fb_idx[j] = IDX_W'(word >> 2);
            hist      = (GLOBAL_HIST != 0) ? ghr_d : bht_q[fb_idx[j]];
            for (int k = 0; k < j; k++) begin
                if (GLOBAL_HIST == 0 && bus.fb_valid[k] && fb_idx[k] == fb_idx[j])
                    hist = fb_hist_new[k];
            end
            fb_pidx[j] = {fb_idx[j], hist};
            ctr        = pht_q[fb_pidx[j]];
            for (int k = 0; k < j; k++) begin
                if (bus.fb_valid[k] && fb_pidx[k] == fb_pidx[j])
                    ctr = fb_ctr_new[k];
            end
            fb_ctr_new[j]  = ctr_sat(ctr, bus.fb_taken[j]);
            fb_hist_new[j] = {hist[HIST_DEPTH-2:0], bus.fb_taken[j]};
            if (GLOBAL_HIST != 0 && bus.fb_valid[j])
                ghr_d = fb_hist_new[j];
        end
    end

    always_comb begin : control
        pending_d      = pending_q;
        pending_addr_d = pending_addr_q;
        pred_valid_d   = pred_valid_q;
        pred_taken_d   = pred_taken_q;
        if (bus.flush) begin
            pending_d    = 1'b0;
            pred_valid_d = 1'b0;
            pred_taken_d = '0;
        end else if (bus.stall) begin
            if (!pending_q && bus.fetch_valid) begin
                pending_d      = 1'b1;
                pending_addr_d = bus.fetch_addr;
            end
        end else if (pending_q) begin
            pending_d    = 1'b0;
            pred_valid_d = 1'b1;
            pred_taken_d = lk_taken;
        end else begin
            pred_valid_d = bus.fetch_valid;
            pred_taken_d = bus.fetch_valid ? lk_taken : '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q    <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= '0;
            ghr_q        <= '0;
            for (int e = 0; e < BHT_ENTRIES; e++) bht_q[e] <= '0;
            for (int e = 0; e < PHT_DEPTH; e++)   pht_q[e] <= CTR_INIT;
        end else begin
            pending_q    <= pending_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            ghr_q        <= ghr_d;
            for (int j = 0; j < NUM_FEEDBACK; j++) begin
                if (bus.fb_valid[j]) begin
                    pht_q[fb_pidx[j]] <= fb_ctr_new[j];
                    if (GLOBAL_HIST == 0) bht_q[fb_idx[j]] <= fb_hist_new[j];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        pending_addr_q <= pending_addr_d;
    end

    assign bus.pred_valid = pred_valid_q;
    assign bus.pred_taken = pred_taken_q;
endmodule

// File: tb/tb_two_level_predictor.sv
// Scoreboard bench for two_level_predictor: a local-history and a global-history
// instance run side by side against a behavioural model of the predictor.
module tb_two_level_predictor;
    localparam int VA  = 32;
    localparam int NF  = 4;
    localparam int NB  = 2;
    localparam int ENT = 1024;
    localparam int HD  = 4;
    localparam int CW  = 2;
    localparam int IW  = 10;
    localparam int PD  = ENT << HD;

    logic clk = 1'b0;
    logic rst_l, rst_g;
    always #5 clk = ~clk;

    two_level_predictor_if #(.VADDR_W(VA), .NUM_FETCH(NF), .NUM_FEEDBACK(NB)) if_l ();
    two_level_predictor_if #(.VADDR_W(VA), .NUM_FETCH(NF), .NUM_FEEDBACK(NB)) if_g ();

    two_level_predictor #(.VADDR_W(VA), .NUM_FETCH(NF), .NUM_FEEDBACK(NB), .BHT_ENTRIES(ENT),
                          .HIST_DEPTH(HD), .CTR_W(CW), .GLOBAL_HIST(0))
        u_loc (.clock(clk), .reset_n(rst_l), .bus(if_l));
    two_level_predictor #(.VADDR_W(VA), .NUM_FETCH(NF), .NUM_FEEDBACK(NB), .BHT_ENTRIES(ENT),
                          .HIST_DEPTH(HD), .CTR_W(CW), .GLOBAL_HIST(1))
        u_glb (.clock(clk), .reset_n(rst_g), .bus(if_g));

    int n_tests, n_fail;

    typedef struct {int k; logic pv; logic [NF-1:0] pt;} exp_t;
    exp_t sbq[$];

    // model state, index 0 = local instance, 1 = global instance
    logic [HD-1:0] m_bht [2][ENT];
    logic [CW-1:0] m_pht [2][PD];
    logic [HD-1:0] m_ghr [2];
    logic          m_pend [2];
    logic [VA-1:0] m_paddr [2];
    logic          m_pv [2];
    logic [NF-1:0] m_pt [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset(input int k);
        for (int e = 0; e < ENT; e++) m_bht[k][e] = '0;
        for (int e = 0; e < PD; e++)  m_pht[k][e] = 2'd1;
        m_ghr[k] = '0; m_pend[k] = 1'b0; m_paddr[k] = '0; m_pv[k] = 1'b0; m_pt[k] = '0;
    endtask

    function automatic logic [NF-1:0] m_lookup(input int k, input logic [VA-1:0] a0);
        logic [NF-1:0] r;
        logic [VA-1:0] a;
        logic [IW-1:0] ix;
        logic [HD-1:0] h;
        r = '0;
        for (int i = 0; i < NF; i++) begin
            a    = a0 + VA'(4 * i);
            ix   = IW'(a >> 2);
            h    = (k == 1) ? m_ghr[1] : m_bht[k][ix];
            r[i] = m_pht[k][{ix, h}][CW-1];
        end
        return r;
    endfunction

    task automatic m_step(input int k, input logic fv, input logic [VA-1:0] fa, input logic st,
                          input logic fl, input logic [NB-1:0] fbv, input logic [NB*VA-1:0] fba,
                          input logic [NB-1:0] fbt);
        logic [NF-1:0] lk;
        logic [VA-1:0] a;
        logic [IW-1:0] ix;
        logic [HD-1:0] h;
        logic [CW-1:0] c;
        lk = m_lookup(k, m_pend[k] ? m_paddr[k] : fa);
        if (fl) begin
            m_pv[k] = 1'b0; m_pt[k] = '0; m_pend[k] = 1'b0;
        end else if (st) begin
            if (!m_pend[k] && fv) begin m_pend[k] = 1'b1; m_paddr[k] = fa; end
        end else if (m_pend[k]) begin
            m_pv[k] = 1'b1; m_pt[k] = lk; m_pend[k] = 1'b0;
        end else begin
            m_pv[k] = fv; m_pt[k] = fv ? lk : '0;
        end
        for (int j = 0; j < NB; j++) begin
            if (fbv[j]) begin
                a  = fba[j*VA +: VA];
                ix = IW'(a >> 2);
                h  = (k == 1) ? m_ghr[1] : m_bht[k][ix];
                c  = m_pht[k][{ix, h}];
                if (fbt[j] && c != 2'd3) c = c + 2'd1;
                else if (!fbt[j] && c != 2'd0) c = c - 2'd1;
                m_pht[k][{ix, h}] = c;
                h = {h[HD-2:0], fbt[j]};
                if (k == 1) m_ghr[1] = h; else m_bht[k][ix] = h;
            end
        end
    endtask

    task automatic set_in(input int k, input logic fv, input logic [VA-1:0] fa,
                          input logic st, input logic fl);
        if (k == 0) begin
            if_l.fetch_valid = fv; if_l.fetch_addr = fa; if_l.stall = st; if_l.flush = fl;
        end else begin
            if_g.fetch_valid = fv; if_g.fetch_addr = fa; if_g.stall = st; if_g.flush = fl;
        end
    endtask

    task automatic set_fb(input int k, input logic [NB-1:0] v, input logic [VA-1:0] a0,
                          input logic [VA-1:0] a1, input logic [NB-1:0] t);
        if (k == 0) begin
            if_l.fb_valid = v; if_l.fb_addr = {a1, a0}; if_l.fb_taken = t;
        end else begin
            if_g.fb_valid = v; if_g.fb_addr = {a1, a0}; if_g.fb_taken = t;
        end
    endtask

    task automatic cycle();
        exp_t e;
        m_step(0, if_l.fetch_valid, if_l.fetch_addr, if_l.stall, if_l.flush,
               if_l.fb_valid, if_l.fb_addr, if_l.fb_taken);
        sbq.push_back('{k: 0, pv: m_pv[0], pt: m_pt[0]});
        m_step(1, if_g.fetch_valid, if_g.fetch_addr, if_g.stall, if_g.flush,
               if_g.fb_valid, if_g.fb_addr, if_g.fb_taken);
        sbq.push_back('{k: 1, pv: m_pv[1], pt: m_pt[1]});
        @(posedge clk);
        #1;
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            if (e.k == 0) begin
                chk("loc_pv", 32'(if_l.pred_valid), 32'(e.pv));
                chk("loc_pt", 32'(if_l.pred_taken), 32'(e.pt));
            end else begin
                chk("glb_pv", 32'(if_g.pred_valid), 32'(e.pv));
                chk("glb_pt", 32'(if_g.pred_taken), 32'(e.pt));
            end
        end
    endtask

    task automatic fb_cycles(input int k, input int n, input logic [NB-1:0] v,
                             input logic [VA-1:0] a0, input logic [VA-1:0] a1, input logic [NB-1:0] t);
        set_fb(k, v, a0, a1, t);
        repeat (n) cycle();
        set_fb(k, '0, '0, '0, '0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst_l = 1'b0; rst_g = 1'b0;
        set_in(0, 0, '0, 0, 0); set_in(1, 0, '0, 0, 0);
        set_fb(0, '0, '0, '0, '0); set_fb(1, '0, '0, '0, '0);
        m_reset(0); m_reset(1);
        #12;
        chk("rst_loc_pv", 32'(if_l.pred_valid), 32'd0);
        chk("rst_loc_pt", 32'(if_l.pred_taken), 32'd0);
        chk("rst_glb_pv", 32'(if_g.pred_valid), 32'd0);
        chk("rst_glb_pt", 32'(if_g.pred_taken), 32'd0);
        rst_l = 1'b1; rst_g = 1'b1;

        // first lookup after reset: all counters weakly not-taken
        set_in(0, 1, 32'h100, 0, 0);
        cycle();
        chk("t1_pv", 32'(if_l.pred_valid), 32'd1);
        chk("t1_pt", 32'(if_l.pred_taken), 32'h0);

        // local history training on 0x104 (slot 1 of 0x100)
        set_in(0, 0, '0, 0, 0);
        fb_cycles(0, 1, 2'b01, 32'h104, '0, 2'b01);
        set_in(0, 1, 32'h100, 0, 0);
        cycle();
        chk("t2_one_taken", 32'(if_l.pred_taken), 32'h0);
        set_in(0, 0, '0, 0, 0);
        fb_cycles(0, 3, 2'b01, 32'h104, '0, 2'b01);
        set_in(0, 1, 32'h100, 0, 0);
        fb_cycles(0, 1, 2'b01, 32'h104, '0, 2'b01);
        chk("t2_read_old", 32'(if_l.pred_taken), 32'h0);
        cycle();
        chk("t2_trained", 32'(if_l.pred_taken), 32'h2);

        // both ports hit 0x200 in the same cycle: updates must chain
        set_in(0, 0, '0, 0, 0);
        fb_cycles(0, 1, 2'b11, 32'h200, 32'h200, 2'b11);
        set_in(0, 1, 32'h200, 0, 0);
        cycle();
        chk("t3_after_one_pair", 32'(if_l.pred_taken), 32'h0);
        set_in(0, 0, '0, 0, 0);
        fb_cycles(0, 2, 2'b11, 32'h200, 32'h200, 2'b11);
        set_in(0, 1, 32'h200, 0, 0);
        cycle();
        chk("t3_chained", 32'(if_l.pred_taken), 32'h1);

        // stall with replay of the captured address; later addresses ignored
        set_in(0, 1, 32'h1FC, 1, 0);
        cycle();
        chk("t4_hold0", 32'(if_l.pred_taken), 32'h1);
        set_in(0, 1, 32'h400, 1, 0);
        cycle();
        chk("t4_hold1", 32'(if_l.pred_taken), 32'h1);
        cycle();
        chk("t4_hold2", 32'(if_l.pred_taken), 32'h1);
        set_in(0, 1, 32'h400, 0, 0);
        cycle();
        chk("t4_replay_pv", 32'(if_l.pred_valid), 32'd1);
        chk("t4_replay_pt", 32'(if_l.pred_taken), 32'h2);
        set_in(0, 0, '0, 0, 0);
        cycle();

        // flush beats stall; nothing replays afterwards
        set_in(0, 1, 32'h1FC, 1, 1);
        cycle();
        chk("t5_flush_pv", 32'(if_l.pred_valid), 32'd0);
        set_in(0, 0, '0, 0, 0);
        cycle();
        chk("t5_no_replay", 32'(if_l.pred_valid), 32'd0);

        // saturation at top then bottom (port 1 alone for the not-taken run)
        fb_cycles(0, 8, 2'b01, 32'h200, '0, 2'b01);
        set_in(0, 1, 32'h200, 0, 0);
        cycle();
        chk("t5_sat_hi", 32'(if_l.pred_taken), 32'h1);
        set_in(0, 0, '0, 0, 0);
        fb_cycles(0, 8, 2'b10, '0, 32'h200, 2'b00);
        set_in(0, 1, 32'h200, 0, 0);
        cycle();
        chk("t5_sat_lo", 32'(if_l.pred_taken), 32'h0);

        // address wrap: slot 2 of 0xFFFFFFF8 is address 0
        set_in(0, 0, '0, 0, 0);
        fb_cycles(0, 3, 2'b11, 32'h0, 32'h0, 2'b11);
        set_in(0, 1, 32'hFFFF_FFF8, 0, 0);
        cycle();
        chk("wrap_pt", 32'(if_l.pred_taken), 32'h4);
        set_in(0, 0, '0, 0, 0);

        // global history: GHR shared across addresses
        fb_cycles(1, 4, 2'b01, 32'h100, '0, 2'b01);
        fb_cycles(1, 1, 2'b01, 32'h800, '0, 2'b01);
        set_in(1, 1, 32'h7FC, 0, 0);
        cycle();
        chk("t6_ghr_pt", 32'(if_g.pred_taken), 32'h2);
        fb_cycles(1, 1, 2'b01, 32'h800, '0, 2'b00);
        cycle();

        // asynchronous reset while a stalled address is pending
        set_in(1, 1, 32'h7FC, 1, 0);
        cycle();
        #2;
        rst_g = 1'b0;
        m_reset(1);
        #1;
        chk("t6_async_pv", 32'(if_g.pred_valid), 32'd0);
        chk("t6_async_pt", 32'(if_g.pred_taken), 32'h0);
        #2;
        rst_g = 1'b1;
        set_in(1, 0, '0, 0, 0);
        cycle();
        chk("t6_pend_dropped", 32'(if_g.pred_valid), 32'd0);

        // taken 0x100 then not-taken 0x800 in one cycle leaves GHR=0010
        fb_cycles(1, 1, 2'b11, 32'h100, 32'h800, 2'b01);
        set_in(1, 1, 32'h100, 0, 0);
        cycle();
        chk("t6_ghr_lookup", 32'(if_g.pred_taken), 32'h0);
        set_in(1, 0, '0, 0, 0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
